// File: rtl/gated_counter_pkg.sv
// Shared types and mode constants for the gated up/down counter.
package gated_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SAT_WRAP = 0;
    localparam int SAT_HALT = 1;

endpackage

// File: rtl/gated_counter_if.sv
// Control and status bundle of the gated counter; master drives controls, slave is the counter.
interface gated_counter_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             tc;
    logic             done;
    logic             stop_dly;

    modport master (
        output start, stop, up_dn, load, load_val,
        input  count, running, tc, done, stop_dly
    );

    modport slave (
        input  start, stop, up_dn, load, load_val,
        output count, running, tc, done, stop_dly
    );
endinterface

// File: rtl/pulse_delay.sv
// Fixed-depth shift register delaying a level by DEPTH clock cycles.
module pulse_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [DEPTH-1:0] r_pipe;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) r_pipe <= '0;
                else     r_pipe <= i_d;
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (rst) r_pipe <= '0;
                else     r_pipe <= {r_pipe[DEPTH-2:0], i_d};
            end
        end
    endgenerate

    assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/gated_counter.sv
// Start/stop gated up/down counter with wrap or halt-at-limit mode and a delayed stop echo.
module gated_counter
    import gated_counter_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int STOP_DELAY = 2,
    parameter int SATURATE   = 0
) (
    input logic           clk,
    input logic           rst,
    gated_counter_if.slave bus
);
    localparam bit             HALT = (SATURATE == SAT_HALT);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_running;
    logic             r_done;

    state_t           w_nxt_state;
    logic [WIDTH-1:0] w_nxt_count;
    logic             w_nxt_tc;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_lim;
    logic             w_at_lim;
    logic             w_reach_lim;

    assign w_step      = bus.up_dn ? (r_count + ONE) : (r_count - ONE);
    assign w_lim       = bus.up_dn ? '1 : '0;
    assign w_at_lim    = (r_count == w_lim);
    assign w_reach_lim = (w_step == w_lim);

    // Load wins over stepping and freezes state, except that stop or DONE still fall back to IDLE.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_count = r_count;
        w_nxt_tc    = 1'b0;
        if (bus.load) begin
            w_nxt_count = bus.load_val;
            if (bus.stop || r_state == ST_DONE) w_nxt_state = ST_IDLE;
        end else if (bus.stop) begin
            w_nxt_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.start) w_nxt_state = ST_RUN;
                ST_RUN: begin
                    if (HALT) begin
                        if (w_at_lim || w_reach_lim) begin
                            w_nxt_count = w_lim;
                            w_nxt_tc    = 1'b1;
                            w_nxt_state = ST_DONE;
                        end else begin
                            w_nxt_count = w_step;
                        end
                    end else begin
                        w_nxt_count = w_step;
                        w_nxt_tc    = w_at_lim;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_tc      <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_count   <= w_nxt_count;
            r_tc      <= w_nxt_tc;
            r_running <= (w_nxt_state == ST_RUN);
            r_done    <= (w_nxt_state == ST_DONE);
        end
    end

    pulse_delay #(
        .DEPTH(STOP_DELAY)
    ) u_stop_delay (
        .clk (clk),
        .rst (rst),
        .i_d (bus.stop),
        .o_q (bus.stop_dly)
    );

    assign bus.count   = r_count;
    assign bus.running = r_running;
    assign bus.tc      = r_tc;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_gated_counter.sv
// Drives a wrapping and a halting counter with shared stimulus; checks both against a behavioural model.
module tb_gated_counter;
    localparam int W   = 4;
    localparam int D   = 2;
    localparam int MAX = (1 << W) - 1;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic         clk;
    logic         rst;
    logic         st, sp, ud, ld;
    logic [W-1:0] lv;

    int n_cmp = 0;
    int n_bad = 0;

    gated_counter_if #(.WIDTH(W)) if0 ();
    gated_counter_if #(.WIDTH(W)) if1 ();

    assign if0.start = st;  assign if1.start = st;
    assign if0.stop  = sp;  assign if1.stop  = sp;
    assign if0.up_dn = ud;  assign if1.up_dn = ud;
    assign if0.load  = ld;  assign if1.load  = ld;
    assign if0.load_val = lv;
    assign if1.load_val = lv;

    gated_counter #(.WIDTH(W), .STOP_DELAY(D), .SATURATE(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    gated_counter #(.WIDTH(W), .STOP_DELAY(D), .SATURATE(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: per-mode integer count, mode and tc, plus stop history queue.
    int m_cnt  [2];
    int m_mode [2];
    bit m_tc   [2];
    bit m_sq   [$];

    initial begin
        for (int i = 0; i < D; i++) m_sq.push_back(1'b0);
        for (int s = 0; s < 2; s++) begin
            m_cnt[s] = 0; m_mode[s] = M_IDLE; m_tc[s] = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) m_sq[i] = 1'b0;
        end else begin
            m_sq.push_front(sp);
            void'(m_sq.pop_back());
        end
        for (int s = 0; s < 2; s++) begin
            int nxt;
            if (rst) begin
                m_cnt[s] = 0; m_mode[s] = M_IDLE; m_tc[s] = 1'b0;
            end else begin
                m_tc[s] = 1'b0;
                if (ld) begin
                    m_cnt[s] = int'(lv);
                    if (sp || m_mode[s] == M_DONE) m_mode[s] = M_IDLE;
                end else if (sp) begin
                    m_mode[s] = M_IDLE;
                end else if (m_mode[s] == M_IDLE) begin
                    if (st) m_mode[s] = M_RUN;
                end else if (m_mode[s] == M_RUN) begin
                    nxt = m_cnt[s] + (ud ? 1 : -1);
                    if (s == 0) begin
                        if (nxt > MAX)    begin nxt = 0;   m_tc[s] = 1'b1; end
                        else if (nxt < 0) begin nxt = MAX; m_tc[s] = 1'b1; end
                    end else begin
                        if (nxt >= MAX)     begin nxt = MAX; m_tc[s] = 1'b1; m_mode[s] = M_DONE; end
                        else if (nxt <= 0)  begin nxt = 0;   m_tc[s] = 1'b1; m_mode[s] = M_DONE; end
                    end
                    m_cnt[s] = nxt;
                end
            end
        end
    end

    function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic cmp_dut(string t, logic [W-1:0] c, logic r, logic tc, logic d, logic sd, int s);
        chk({t, ".count"},    16'(c),  16'(m_cnt[s]));
        chk({t, ".running"},  16'(r),  16'(m_mode[s] == M_RUN));
        chk({t, ".tc"},       16'(tc), 16'(m_tc[s]));
        chk({t, ".done"},     16'(d),  16'(m_mode[s] == M_DONE));
        chk({t, ".stop_dly"}, 16'(sd), 16'(m_sq[D-1]));
    endtask

    always @(negedge clk) begin
        cmp_dut("model.d0", if0.count, if0.running, if0.tc, if0.done, if0.stop_dly, 0);
        cmp_dut("model.d1", if1.count, if1.running, if1.tc, if1.done, if1.stop_dly, 1);
    end

    task automatic step(bit r, bit a, bit p, bit u, bit l, int v);
        rst = r; st = a; sp = p; ud = u; ld = l; lv = W'(v);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Literal expectations: count, running, tc, done for one instance.
    task automatic lit(int s, string tag, int c, int r, int t, int d);
        if (s == 0) begin
            chk({tag, ".d0.count"}, 16'(if0.count), 16'(c));
            chk({tag, ".d0.running"}, 16'(if0.running), 16'(r));
            chk({tag, ".d0.tc"}, 16'(if0.tc), 16'(t));
            chk({tag, ".d0.done"}, 16'(if0.done), 16'(d));
        end else begin
            chk({tag, ".d1.count"}, 16'(if1.count), 16'(c));
            chk({tag, ".d1.running"}, 16'(if1.running), 16'(r));
            chk({tag, ".d1.tc"}, 16'(if1.tc), 16'(t));
            chk({tag, ".d1.done"}, 16'(if1.done), 16'(d));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; st = 1'b0; sp = 1'b0; ud = 1'b1; ld = 1'b0; lv = '0;
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        lit(0, "reset", 0, 0, 0, 0);
        lit(1, "reset", 0, 0, 0, 0);
        chk("reset.stop_dly", 16'(if0.stop_dly), 16'd0);

        // start for one cycle, count five edges, then stop
        step(0, 1, 0, 1, 0, 0);
        lit(0, "start", 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 0, 1, 0, 0);
            chk("run.count", 16'(if0.count), 16'(k));
        end
        step(0, 0, 1, 1, 0, 0);
        lit(0, "stop", 5, 0, 0, 0);
        chk("stop.sd0", 16'(if0.stop_dly), 16'd0);
        step(0, 0, 0, 1, 0, 0);
        chk("stop.sd1", 16'(if0.stop_dly), 16'd1);
        chk("stop.hold", 16'(if0.count), 16'd5);
        step(0, 0, 0, 1, 0, 0);
        chk("stop.sd2", 16'(if0.stop_dly), 16'd0);

        // wrap from 15 up, and halt at 15 for the saturating instance
        step(0, 0, 0, 1, 1, 14);
        lit(0, "load14", 14, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        lit(0, "wrapstart", 14, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        lit(0, "wrap15", 15, 1, 0, 0);
        lit(1, "sat15", 15, 0, 1, 1);
        step(0, 0, 0, 1, 0, 0);
        lit(0, "wrap0", 0, 1, 1, 0);
        lit(1, "sathold", 15, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        lit(0, "wrap1", 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        lit(1, "satstop", 15, 0, 0, 0);

        // saturating count down to 0
        step(0, 0, 0, 0, 1, 2);
        step(0, 1, 0, 0, 0, 0);
        lit(1, "dn.start", 2, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        lit(1, "dn.1", 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        lit(1, "dn.0", 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0);
        lit(1, "dn.hold", 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        lit(1, "dn.ignstart", 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        lit(1, "dn.stop", 0, 0, 0, 0);

        // start and stop together from IDLE
        step(1, 0, 0, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        lit(0, "both", 0, 0, 0, 0);
        chk("both.sd0", 16'(if0.stop_dly), 16'd0);
        step(0, 0, 0, 1, 0, 0);
        chk("both.sd1", 16'(if0.stop_dly), 16'd1);
        step(0, 0, 0, 1, 0, 0);
        chk("both.sd2", 16'(if0.stop_dly), 16'd0);

        // reset mid-run at 7 with a stop sampled on the reset edge
        step(0, 0, 1, 1, 1, 7);
        lit(0, "ldstop", 7, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        lit(0, "run7", 7, 1, 0, 0);
        chk("run7.sd", 16'(if0.stop_dly), 16'd1);
        step(1, 0, 1, 1, 0, 0);
        lit(0, "rstmid", 0, 0, 0, 0);
        chk("rstmid.sd0", 16'(if0.stop_dly), 16'd0);
        step(0, 0, 0, 1, 0, 0);
        chk("rstmid.sd1", 16'(if0.stop_dly), 16'd0);
        step(0, 0, 0, 1, 0, 0);
        chk("rstmid.sd2", 16'(if0.stop_dly), 16'd0);

        // load while running
        step(0, 0, 0, 1, 1, 9);
        step(0, 1, 0, 1, 0, 0);
        lit(0, "run9", 9, 1, 0, 0);
        step(0, 0, 0, 1, 1, 3);
        lit(0, "ldrun", 3, 1, 0, 0);
        lit(1, "ldrun", 3, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        lit(0, "ldrun4", 4, 1, 0, 0);

        // randomized phase, checked every cycle by the model compare
        for (int n = 0; n < 4000; n++) begin
            bit u;
            u = ((n % 50) == 0 || ($urandom % 8) == 0) ? bit'($urandom % 2) : ud;
            step(bit'(($urandom % 64) == 0), bit'(($urandom % 4) == 0),
                 bit'(($urandom % 10) == 0), u,
                 bit'(($urandom % 20) == 0), int'($urandom % (MAX + 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
